mbc1_cart: RTL and testbench
============================

Name: mbc1_cart

Overview:
- Cartridge-side responder for the DMG CPU cartridge bus. It is the other end of the ROM reads dmg_main issues.
- Implements MBC1 bank switching:
  - decodes CPU writes into bank and control registers;
  - translates CPU addresses into banked ROM addresses for the synchronous cart_prom;
  - serves banked external cart RAM.
- Sits between dmg_main's cart bus and cart_prom, plus an internal SRAM.

Parameters:
- ROM_AW, 15, ROM byte-address width; physical ROM address wraps modulo 2**ROM_AW.
- RAM_AW, 13, cart RAM byte-address width; 0 means no RAM fitted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_wr  in  1  write strobe, one cycle per access.
- cpu_rd  in  1  read strobe, one cycle per access.
- cpu_rdata  out  8  read data; meaningful only while cpu_rvalid.
- cpu_rvalid  out  1  read response pulse.
- rom_addr  out  ROM_AW  address to cart_prom (registered dout, 1-cycle latency).
- rom_data  in  8  cart_prom dout.

Behaviour:
- Registers and reset values:
  - ram_en = 0
  - bank_lo[4:0] = 0
  - bank_hi[1:0] = 0
  - mode = 0
  - cpu_rvalid = 0
  - cpu_rdata = 8'hFF
- Register writes (cpu_wr, cpu_addr[15] = 0), applied at the clock edge:
  - 0000-1FFF: ram_en <= (cpu_wdata[3:0] == 4'hA).
  - 2000-3FFF: bank_lo <= cpu_wdata[4:0].
  - 4000-5FFF: bank_hi <= cpu_wdata[1:0].
  - 6000-7FFF: mode <= cpu_wdata[0].
- Effective low bank: lo_eff = (bank_lo == 0) ? 1 : bank_lo. The zero check applies to the full 5 bits before any masking, so writing 8'h20 yields lo_eff = 1.
- ROM mapping. rom_addr is combinational from cpu_addr and the current registers, truncated to ROM_AW bits:
  - 0000-3FFF: {mode ? {bank_hi, 5'b0} : 7'd0, cpu_addr[13:0]}.
  - 4000-7FFF: {bank_hi, lo_eff, cpu_addr[13:0]}.
- RAM mapping (A000-BFFF): ram address {mode ? bank_hi : 2'b0, cpu_addr[12:0]}, truncated to RAM_AW bits.
  - Write with ram_en = 1: stored at the edge.
  - Write with ram_en = 0, or RAM_AW = 0: ignored.
- Read timing: cpu_rd sampled at edge N. Source select is registered at N. cpu_rvalid is high for exactly cycle N+1. cpu_rdata is selected from:
  - rom_data, for 0000-7FFF;
  - SRAM q, for A000-BFFF with ram_en = 1;
  - 8'hFF, for a disabled RAM read or any other address.
- Pipelining: back-to-back reads, one per cycle, are supported; cpu_rvalid stays high continuously.
- cpu_rd and cpu_wr asserted together: the write wins, the read is dropped, and there is no cpu_rvalid.
- Bank register written in the same cycle a read is issued (wr wins, so only with sequential accesses): a read issued at edge N uses the register values before edge N. A write at edge N affects reads issued at N+1 onward.
- Region lookup uses the ram_en captured with the read.
- Reset mid-read: cpu_rvalid drops immediately and all registers return to reset values; the in-flight read is lost.

Decomposition:
- Package dmg_cart_pkg:
  - region enum (REG_RAMEN, REG_BANKLO, REG_BANKHI, REG_MODE, ROM0, ROMX, XRAM, NONE);
  - region decode function;
  - RAM_ENABLE_KEY = 4'hA;
  - OPEN_BUS = 8'hFF;
  - reset constants for the bank registers.
- Sub-module cart_sram: single-port synchronous RAM, 2**RAM_AW x 8, 1-cycle read, write-first not required.

Test Plan:
- Reset, then rd 16'h4123 → rom_addr = 15'h4123 (bank 1); cpu_rvalid one cycle later with rom_data.
- ROM_AW = 19: write 2000 ← 8'h00 → bank 1; write 8'h05 then rd 4010 → rom_addr = 19'h14010; write 4000 ← 2, mode ← 1, rd 0010 → rom_addr = 19'h100010 truncated = 19'h00010.
- RAM: rd/wr to A000 with ram_en = 0 → rdata 8'hFF and no store; write 0000 ← 8'h0A, write A005 ← 8'h5C, rd A005 → 8'h5C; write 0000 ← 8'h00 → rd returns 8'hFF.
- Bank_hi = 1 with mode = 0 vs mode = 1 (RAM_AW = 15): write via A001 lands at RAM address 0x0001 vs 0x2001; read back is consistent.
- Back-to-back rd on 3 consecutive cycles → 3 consecutive cpu_rvalid cycles with in-order data; simultaneous rd + wr to 2000 → bank updated, no rvalid.
- Assert rst low during an outstanding read → cpu_rvalid = 0 asynchronously; after release, bank reads map to bank 1 and ram_en = 0.

Source files
------------

// File: rtl/dmg_cart_pkg.sv
// Shared types and constants for the MBC1 cartridge responder.
package dmg_cart_pkg;

   // Bus regions; register regions only apply to writes below 8000.
   typedef enum logic [2:0] {
      REG_RAMEN,
      REG_BANKLO,
      REG_BANKHI,
      REG_MODE,
      ROM0,
      ROMX,
      XRAM,
      NONE
   } region_t;

   // Source of the read data returned one cycle after a read strobe.
   typedef enum logic [1:0] {
      SRC_OPEN,
      SRC_ROM,
      SRC_RAM
   } src_t;

   localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;
   localparam logic [7:0] OPEN_BUS       = 8'hFF;
   localparam logic [4:0] BANK_LO_RST    = 5'd0;
   localparam logic [1:0] BANK_HI_RST    = 2'd0;
   localparam logic       MODE_RST       = 1'b0;

   // Classify an access from the top three address bits.
   // Writes below 8000 hit the control registers, reads there hit ROM.
   function automatic region_t decode_region(input logic [2:0] addr_hi,
                                             input logic       is_wr);
      region_t r;
      r = NONE;
      if (!addr_hi[2]) begin
         if (is_wr) begin
            case (addr_hi[1:0])
               2'b00:   r = REG_RAMEN;
               2'b01:   r = REG_BANKLO;
               2'b10:   r = REG_BANKHI;
               default: r = REG_MODE;
            endcase
         end else begin
            r = addr_hi[1] ? ROMX : ROM0;
         end
      end else if (addr_hi[1:0] == 2'b01) begin
         r = XRAM;
      end
      return r;
   endfunction

endpackage

// File: rtl/cart_sram.sv
// Single-port synchronous cartridge RAM, 2**AW x 8, one-cycle read.
module cart_sram #(
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    q
);

   logic [7:0] mem [2**AW];

   // Write on we, always register the read port (read-during-write returns old data).
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/mbc1_cart.sv
// MBC1 cartridge responder: bank/control registers, ROM address
// translation for a synchronous PROM, and banked external RAM.
module mbc1_cart
   import dmg_cart_pkg::*;
#(
   parameter int ROM_AW = 15,
   parameter int RAM_AW = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_wdata,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_data
);

   // Keep declarations legal when no RAM is fitted.
   localparam int RAM_AI = (RAM_AW > 0) ? RAM_AW : 1;

   logic        ram_en_q,  ram_en_d;
   logic [4:0]  bank_lo_q, bank_lo_d;
   logic [1:0]  bank_hi_q, bank_hi_d;
   logic        mode_q,    mode_d;
   logic        rvalid_q,  rvalid_d;
   src_t        src_q,     src_d;

   region_t     rd_region;
   region_t     wr_region;
   logic [4:0]  lo_eff;
   logic [1:0]  hi_sel;
   logic [20:0] rom_full;
   logic [14:0] ram_full;
   logic [RAM_AI-1:0] ram_addr;
   logic        ram_we;
   logic [7:0]  sram_q;

   assign rd_region = decode_region(cpu_addr[15:13], 1'b0);
   assign wr_region = decode_region(cpu_addr[15:13], 1'b1);

   // Bank 0 in the switchable window is remapped to bank 1 (full 5-bit test).
   assign lo_eff = (bank_lo_q == 5'd0) ? 5'd1 : bank_lo_q;
   // Upper bank bits only reach ROM0 and RAM in mode 1.
   assign hi_sel = mode_q ? bank_hi_q : 2'b00;

   // Combinational ROM address from the current (pre-edge) registers.
   always_comb begin
      rom_full = {hi_sel, 5'd0, cpu_addr[13:0]};
      if (cpu_addr[14]) begin
         rom_full = {bank_hi_q, lo_eff, cpu_addr[13:0]};
      end
   end

   assign rom_addr = ROM_AW'(rom_full);
   assign ram_full = {hi_sel, cpu_addr[12:0]};
   assign ram_addr = RAM_AI'(ram_full);
   assign ram_we   = cpu_wr && (wr_region == XRAM) && ram_en_q;

   // Register-write decode and read-source capture; a write suppresses a coincident read.
   always_comb begin
      ram_en_d  = ram_en_q;
      bank_lo_d = bank_lo_q;
      bank_hi_d = bank_hi_q;
      mode_d    = mode_q;
      rvalid_d  = 1'b0;
      src_d     = SRC_OPEN;
      if (cpu_wr) begin
         case (wr_region)
            REG_RAMEN:  ram_en_d  = (cpu_wdata[3:0] == RAM_ENABLE_KEY);
            REG_BANKLO: bank_lo_d = cpu_wdata[4:0];
            REG_BANKHI: bank_hi_d = cpu_wdata[1:0];
            REG_MODE:   mode_d    = cpu_wdata[0];
            default:    ;
         endcase
      end else if (cpu_rd) begin
         rvalid_d = 1'b1;
         case (rd_region)
            ROM0, ROMX: src_d = SRC_ROM;
            XRAM:       src_d = (ram_en_q && (RAM_AW > 0)) ? SRC_RAM : SRC_OPEN;
            default:    src_d = SRC_OPEN;
         endcase
      end
   end

   // State registers; reset also kills any in-flight read response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_en_q  <= 1'b0;
         bank_lo_q <= BANK_LO_RST;
         bank_hi_q <= BANK_HI_RST;
         mode_q    <= MODE_RST;
         rvalid_q  <= 1'b0;
         src_q     <= SRC_OPEN;
      end else begin
         ram_en_q  <= ram_en_d;
         bank_lo_q <= bank_lo_d;
         bank_hi_q <= bank_hi_d;
         mode_q    <= mode_d;
         rvalid_q  <= rvalid_d;
         src_q     <= src_d;
      end
   end

   // Read data mux; idle and open-bus cycles present FF.
   always_comb begin
      cpu_rdata = OPEN_BUS;
      case (src_q)
         SRC_ROM: cpu_rdata = rom_data;
         SRC_RAM: cpu_rdata = sram_q;
         default: cpu_rdata = OPEN_BUS;
      endcase
   end

   assign cpu_rvalid = rvalid_q;

   generate
      if (RAM_AW > 0) begin : g_ram
         cart_sram #(.AW(RAM_AI)) u_sram (
            .clk   (clk),
            .we    (ram_we),
            .addr  (ram_addr),
            .wdata (cpu_wdata),
            .q     (sram_q)
         );
      end else begin : g_no_ram
         assign sram_q = OPEN_BUS;
      end
   endgenerate

endmodule

// File: tb/tb_mbc1_cart.sv
// Directed bench for mbc1_cart: a 19-bit-ROM/15-bit-RAM instance and a
// 21-bit-ROM/no-RAM instance driven by the same CPU bus.
module tb_mbc1_cart;

   localparam int OP_WR = 0;
   localparam int OP_RD = 1;
   localparam int OP_RW = 2;

   typedef struct {
      int          op;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [20:0] exp_ra;   // full unwrapped ROM address for ROM reads
      logic [7:0]  exp_ram;  // expected data for non-ROM reads (RAM instance)
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cpu_addr  = 16'h0;
   logic [7:0]  cpu_wdata = 8'h0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;

   logic [7:0]  rdata19, rdata21;
   logic        rvalid19, rvalid21;
   logic [18:0] rom_addr19;
   logic [20:0] rom_addr21;
   logic [7:0]  rom_data19, rom_data21;

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mbc1_cart #(.ROM_AW(19), .RAM_AW(15)) u_dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(rdata19),
      .cpu_rvalid(rvalid19), .rom_addr(rom_addr19), .rom_data(rom_data19)
   );

   mbc1_cart #(.ROM_AW(21), .RAM_AW(0)) u_dut21 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(rdata21),
      .cpu_rvalid(rvalid21), .rom_addr(rom_addr21), .rom_data(rom_data21)
   );

   // ROM content is a hash of the address so a wrong bank shows as wrong data.
   function automatic logic [7:0] rom_fn(input logic [20:0] a);
      return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]};
   endfunction

   // Synchronous PROM models with one-cycle registered output.
   always @(posedge clk) begin
      rom_data19 <= rom_fn({2'b00, rom_addr19});
      rom_data21 <= rom_fn(rom_addr21);
   end

   function automatic vec_t mk(input int op, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [20:0] ra,
                               input logic [7:0] ram);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.exp_ra = ra; v.exp_ram = ram;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access: drive at negedge, check rom_addr before the edge, response after it.
   task automatic apply(input vec_t v, input string tag);
      logic [7:0] e19, e21;
      @(negedge clk);
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      cpu_rd    = (v.op != OP_WR);
      cpu_wr    = (v.op != OP_RD);
      #1;
      if (v.op == OP_RD && !v.addr[15]) begin
         chk({tag, " rom_addr19"}, 32'(rom_addr19), 32'(v.exp_ra[18:0]));
         chk({tag, " rom_addr21"}, 32'(rom_addr21), 32'(v.exp_ra));
      end
      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      if (v.op == OP_RD) begin
         if (!v.addr[15]) begin
            e19 = rom_fn({2'b00, v.exp_ra[18:0]});
            e21 = rom_fn(v.exp_ra);
         end else begin
            e19 = v.exp_ram;
            e21 = 8'hFF;
         end
         chk({tag, " rvalid19"}, 32'(rvalid19), 32'd1);
         chk({tag, " rvalid21"}, 32'(rvalid21), 32'd1);
         chk({tag, " rdata19"}, 32'(rdata19), 32'(e19));
         chk({tag, " rdata21"}, 32'(rdata21), 32'(e21));
      end else begin
         chk({tag, " no_rvalid19"}, 32'(rvalid19), 32'd0);
         chk({tag, " no_rvalid21"}, 32'(rvalid21), 32'd0);
      end
      $display("vec %s op=%0d addr=%h wdata=%h rvalid=%b rdata19=%h rdata21=%h",
               tag, v.op, v.addr, v.wdata, rvalid19, rdata19, rdata21);
   endtask

   initial begin
      logic [15:0] b2b_addr [3];
      logic [20:0] b2b_ra   [3];
      logic [7:0]  e19, e21;

      // ROM banking
      vecs.push_back(mk(OP_RD, 16'h4123, 8'h00, 21'h004123, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h0000, 8'h00, 21'h000000, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h2000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h4010, 8'h00, 21'h004010, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h2000, 8'h05, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h4010, 8'h00, 21'h014010, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h4000, 8'h02, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h4010, 8'h00, 21'h114010, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h0010, 8'h00, 21'h000010, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h6000, 8'h01, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h0010, 8'h00, 21'h100010, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h3FFF, 8'h00, 21'h103FFF, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h2000, 8'h20, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h4000, 8'h00, 21'h104000, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h2000, 8'h1F, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h7FFF, 8'h00, 21'h17FFFF, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h6000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h4000, 8'h00, 21'h0, 8'hFF));
      // RAM enable / disable
      vecs.push_back(mk(OP_RD, 16'hA000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h0000, 8'h0A, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'hA000, 8'h11, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h0000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'hA000, 8'h77, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h0000, 8'h1A, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA000, 8'h00, 21'h0, 8'h11));
      vecs.push_back(mk(OP_WR, 16'hA005, 8'h5C, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA005, 8'h00, 21'h0, 8'h5C));
      vecs.push_back(mk(OP_WR, 16'h0000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA005, 8'h00, 21'h0, 8'hFF));
      // RAM banking by mode
      vecs.push_back(mk(OP_WR, 16'h0000, 8'h0A, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h4000, 8'h01, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'hA001, 8'hAA, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'h6000, 8'h01, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_WR, 16'hA001, 8'hBB, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA001, 8'h00, 21'h0, 8'hBB));
      vecs.push_back(mk(OP_WR, 16'h6000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'hA001, 8'h00, 21'h0, 8'hAA));
      // Unmapped regions
      vecs.push_back(mk(OP_RD, 16'hC000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h8000, 8'h00, 21'h0, 8'hFF));
      // Simultaneous rd+wr: write lands, no response
      vecs.push_back(mk(OP_WR, 16'h4000, 8'h00, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RW, 16'h2000, 8'h03, 21'h0, 8'hFF));
      vecs.push_back(mk(OP_RD, 16'h4000, 8'h00, 21'h00C000, 8'hFF));

      // Reset state
      #1;
      chk("reset rvalid19", 32'(rvalid19), 32'd0);
      chk("reset rvalid21", 32'(rvalid21), 32'd0);
      chk("reset rdata19", 32'(rdata19), 32'hFF);
      chk("reset rdata21", 32'(rdata21), 32'hFF);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("v%0d", i));
      end

      // Back-to-back reads (bank_lo=3, bank_hi=0, mode=0, ram_en=1)
      b2b_addr[0] = 16'h4001; b2b_ra[0] = 21'h00C001;
      b2b_addr[1] = 16'hA005; b2b_ra[1] = 21'h0;
      b2b_addr[2] = 16'h0002; b2b_ra[2] = 21'h000002;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cpu_addr = b2b_addr[i];
         cpu_rd   = 1'b1;
         @(posedge clk);
         #1;
         if (i == 1) begin
            e19 = 8'h5C;
            e21 = 8'hFF;
         end else begin
            e19 = rom_fn(b2b_ra[i]);
            e21 = rom_fn(b2b_ra[i]);
         end
         chk($sformatf("b2b%0d rvalid19", i), 32'(rvalid19), 32'd1);
         chk($sformatf("b2b%0d rvalid21", i), 32'(rvalid21), 32'd1);
         chk($sformatf("b2b%0d rdata19", i), 32'(rdata19), 32'(e19));
         chk($sformatf("b2b%0d rdata21", i), 32'(rdata21), 32'(e21));
         $display("b2b %0d addr=%h rvalid=%b rdata19=%h rdata21=%h",
                  i, b2b_addr[i], rvalid19, rdata19, rdata21);
      end
      @(negedge clk);
      cpu_rd = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b end rvalid19", 32'(rvalid19), 32'd0);

      // Reset during an outstanding read, with non-default banking in place
      apply(mk(OP_WR, 16'h6000, 8'h01, 21'h0, 8'hFF), "pre_rst_mode");
      apply(mk(OP_WR, 16'h4000, 8'h02, 21'h0, 8'hFF), "pre_rst_hi");
      @(negedge clk);
      cpu_addr = 16'h4000;
      cpu_rd   = 1'b1;
      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
      chk("inflight rvalid19", 32'(rvalid19), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async rst rvalid19", 32'(rvalid19), 32'd0);
      chk("async rst rvalid21", 32'(rvalid21), 32'd0);
      chk("async rst rdata19", 32'(rdata19), 32'hFF);
      $display("rst mid-read rvalid19=%b rvalid21=%b rdata19=%h", rvalid19, rvalid21, rdata19);
      @(negedge clk);
      rst = 1'b1;
      apply(mk(OP_RD, 16'h4000, 8'h00, 21'h004000, 8'hFF), "post_rst_bank");
      apply(mk(OP_RD, 16'h0010, 8'h00, 21'h000010, 8'hFF), "post_rst_mode");
      apply(mk(OP_RD, 16'hA005, 8'h00, 21'h0, 8'hFF), "post_rst_ramen");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
